// File: rtl/fir_cfg_pkg.sv
// Shared definitions for the FIR configuration master: FSM encoding,
// FIR register map and ap_ctrl bit positions.
package fir_cfg_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_RD_A = 3'd2;
    localparam logic [2:0] ST_RD_D = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_WR   = ST_WR,
        S_RD_A = ST_RD_A,
        S_RD_D = ST_RD_D,
        S_RSP  = ST_RSP
    } fsm_state_t;

    // FIR register map (byte addresses)
    localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
    localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
    localparam logic [11:0] ADDR_TAP_BASE = 12'h020;

    // ap_ctrl bit indices
    localparam int AP_START = 0;
    localparam int AP_DONE  = 1;
    localparam int AP_IDLE  = 2;

    // Byte address of coefficient tap number idx
    function automatic logic [11:0] tap_addr(input int unsigned idx);
        return ADDR_TAP_BASE + 12'(idx * 4);
    endfunction

endpackage

// File: rtl/fir_cfg_wdog.sv
// Per-transaction watchdog: saturating cycle counter with a timeout flag.
// timeout is high while enabled and the counter sits at pTIMEOUT-1.
module fir_cfg_wdog #(
    parameter int pTIMEOUT = 255
) (
    input  logic axis_clk,
    input  logic axis_rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int          CW   = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(pTIMEOUT - 1);

    logic [CW-1:0] count_q;

    // Count busy cycles; hold at LAST instead of wrapping
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign timeout = enable && (count_q == LAST);

endmodule

// File: rtl/fir_cfg_master.sv
// AXI-Lite initiator (AW/W/AR/R, no B channel) for the FIR configuration
// port. Turns one command into one register write or read and returns one
// response; a watchdog aborts transactions the slave never answers.
//
// Handshake rule on every channel (cmd, rsp, aw, w, ar, r): a transfer
// happens on the rising edge where valid and ready are both 1. A raised
// valid is held, with its payload frozen, until that edge; only a watchdog
// timeout or reset may drop it early. ready may toggle freely.
module fir_cfg_master
    import fir_cfg_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 255
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // command
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    // response
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    // write address / data
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    // read address / data
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    // debug
    output logic [2:0]             dbg_state
);

    fsm_state_t             state_q, state_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [pDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_timeout;
    logic aw_fin;
    logic w_fin;

    assign wd_clear  = (state_q == S_IDLE) && cmd_valid;
    assign wd_enable = (state_q == S_WR) || (state_q == S_RD_A) || (state_q == S_RD_D);

    // A channel counts as finished if it completed earlier or completes this cycle
    assign aw_fin = aw_done_q || (awvalid_q && awready);
    assign w_fin  = w_done_q  || (wvalid_q  && wready);

    fir_cfg_wdog #(
        .pTIMEOUT (pTIMEOUT)
    ) u_wdog (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .clear      (wd_clear),
        .enable     (wd_enable),
        .timeout    (wd_timeout)
    );

    // State, channel and response registers
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state and next-register values; every branch starts from "hold"
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_we) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else if (wd_timeout) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            S_RD_A: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_D;
                end else if (wd_timeout) begin
                    arvalid_d   = 1'b0;
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            S_RD_D: begin
                if (rvalid) begin
                    rready_d    = 1'b0;
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = rdata;
                end else if (wd_timeout) begin
                    rready_d    = 1'b0;
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = addr_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign arvalid   = arvalid_q;
    assign araddr    = addr_q;
    assign rready    = rready_q;
    assign dbg_state = state_q;

endmodule
